// File: rtl/instr_mem_ctrl.sv
// Instruction memory with a valid/ready fetch port and a runtime programming port.
// The synchronous read lands directly in a 2-entry response FIFO at the accepting
// edge. The word is therefore visible on rsp_* one cycle after the request, and
// no request stays in flight across a cycle boundary. The ownership limit
// (buffered plus in flight) reduces to the FIFO occupancy.
// Faulted fetches (misaligned or beyond DEPTH) never touch the array; they return
// NOP_WORD with rsp_fault set. Programming is only allowed in S_PROG, which is
// reached after the response FIFO has drained.
module instr_mem_ctrl #(
    parameter int                 DATA_W    = 32,
    parameter int                 ADDR_W    = 32,
    parameter int                 DEPTH     = 1024,
    parameter string              INIT_FILE = "",
    parameter logic [DATA_W-1:0]  NOP_WORD  = DATA_W'(32'h00000013)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_fault,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_wdata,
    output logic              prog_err,
    output logic              busy
);

    localparam int                IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W-3:0] IDX_LIM = (ADDR_W-2)'(DEPTH);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_PROG  = 2'd2
    } state_t;

    // Word addresses use a fixed 4-byte stride regardless of DATA_W.
    function automatic logic addr_fault(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a[ADDR_W-1:2] >= IDX_LIM);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    logic [1:0]        count;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [DATA_W-1:0] ent_data_p1  [2];
    logic              ent_fault_p1 [2];

    logic              req_fault_p0;
    logic [IDX_W-1:0]  req_idx_p0;
    logic              prog_fault;
    logic [IDX_W-1:0]  prog_idx;
    logic              push;
    logic              pop;
    logic              prog_wr_ok;

    assign req_fault_p0 = addr_fault(req_addr);
    assign req_idx_p0   = req_addr[IDX_W+1:2];
    assign prog_fault   = addr_fault(prog_addr);
    assign prog_idx     = prog_addr[IDX_W+1:2];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts
    // when the consumer is draining it.
    assign rsp_valid  = (count != 2'd0) && (state != S_PROG);
    assign pop        = rsp_valid && rsp_ready;
    assign req_ready  = (state == S_RUN) && !prog_en && ((count != 2'd2) || pop);
    assign push       = req_valid && req_ready;
    assign rsp_data   = ent_data_p1[rd_ptr];
    assign rsp_fault  = ent_fault_p1[rd_ptr];
    assign busy       = (state != S_RUN);
    assign prog_wr_ok = (state == S_PROG) && prog_we && !prog_fault && !rst;

    // Program port writes; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (prog_wr_ok) begin
            mem[prog_idx] <= prog_wdata;
        end
    end

    // ---- stage p0 -> p1: synchronous read into the response FIFO slot ----
    // Write the fetched word (or NOP_WORD on a fault) into the tail entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                ent_data_p1[i]  <= '0;
                ent_fault_p1[i] <= 1'b0;
            end
        end else if (push) begin
            ent_data_p1[wr_ptr]  <= req_fault_p0 ? NOP_WORD : mem[req_idx_p0];
            ent_fault_p1[wr_ptr] <= req_fault_p0;
        end
    end

    // Track FIFO occupancy and head/tail pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Mode FSM: run, drain the FIFO before programming, program, and the
    // registered one-cycle rejection pulse for bad program addresses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RUN;
            prog_err <= 1'b0;
        end else begin
            prog_err <= (state == S_PROG) && prog_we && prog_fault;
            case (state)
                S_RUN: begin
                    if (prog_en) begin
                        state <= (count == 2'd0) ? S_PROG : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!prog_en) begin
                        state <= S_RUN;
                    end else if (count == 2'd0) begin
                        state <= S_PROG;
                    end
                end
                S_PROG: begin
                    if (!prog_en) begin
                        state <= S_RUN;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: directed steps followed by a randomized phase, all
// checked every cycle against a queue-based behavioural model of the fetch port.
module tb_instr_mem_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 1024;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam int M_RUN = 0, M_DRAIN = 1, M_PROG = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_fault;
    logic              prog_en = 1'b0;
    logic              prog_we = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [DATA_W-1:0] prog_wdata = '0;
    logic              prog_err;
    logic              busy;

    always #5 clk = ~clk;

    instr_mem_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_fault (rsp_fault),
        .prog_en   (prog_en),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_wdata(prog_wdata),
        .prog_err  (prog_err),
        .busy      (busy)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mmem [DEPTH];
    logic [32:0] mq [$];
    int          mst  = M_RUN;
    logic        merr = 1'b0;

    function automatic bit mfault(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs with the model, then advance both.
    task automatic cyc();
        bit          mvalid, mready, pop, push;
        logic [32:0] head;
        #1;
        mvalid = (mq.size() != 0);
        mready = (mst == M_RUN) && !prog_en && ((mq.size() < 2) || (mvalid && rsp_ready));
        chk("req_ready", req_ready, mready);
        chk("rsp_valid", rsp_valid, mvalid);
        if (mvalid) begin
            head = mq[0];
            chk("rsp_data", rsp_data, head[31:0]);
            chk("rsp_fault", rsp_fault, head[32]);
        end
        chk("busy", busy, mst != M_RUN);
        chk("prog_err", prog_err, merr);
        pop  = mvalid && rsp_ready;
        push = req_valid && mready;
        if (rst) begin
            mq.delete();
            mst  = M_RUN;
            merr = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(mfault(req_addr) ? {1'b1, NOP} : {1'b0, mmem[req_addr / 4]});
            merr = (mst == M_PROG) && prog_we && mfault(prog_addr);
            if ((mst == M_PROG) && prog_we && !mfault(prog_addr)) mmem[prog_addr / 4] = prog_wdata;
            case (mst)
                M_RUN:   if (prog_en) mst = mvalid ? M_DRAIN : M_PROG;
                M_DRAIN: if (!prog_en) mst = M_RUN; else if (!mvalid) mst = M_PROG;
                default: if (!prog_en) mst = M_RUN;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        cyc();
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic enter_prog();
        int n;
        req_valid = 1'b0;
        prog_en   = 1'b1;
        n = 0;
        while (mst != M_PROG && n < 10) begin
            cyc();
            n++;
        end
        chk("prog_entry_bound", mst == M_PROG, 1);
    endtask

    initial begin
        // Reset.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_fault", rsp_fault, 0);
        chk("rst_prog_err", prog_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);
        @(posedge clk);
        #1;

        // Load the whole memory through the programming port.
        enter_prog();
        prog_we = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            prog_addr  = i * 4;
            prog_wdata = (i == 0) ? 32'h00100093 : (i < 6) ? 32'h00200113 : $urandom;
            cyc();
        end
        prog_we = 1'b0;
        prog_en = 1'b0;
        cyc();

        // Back-to-back fetches with the consumer always ready.
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) fetch(i * 4);
        idle(2);

        // Stall: only two words may be owned.
        rsp_ready = 1'b0;
        fetch(0);
        fetch(4);
        fetch(8);
        fetch(8);
        rsp_ready = 1'b1;
        fetch(8);
        idle(3);

        // Faulted fetches, then a normal one.
        fetch(2);
        fetch(4096);
        fetch(0);
        idle(2);

        // Drain into programming mode, good and rejected writes, refetch.
        rsp_ready = 1'b0;
        fetch(0);
        fetch(4);
        req_valid = 1'b0;
        prog_en   = 1'b1;
        cyc();
        cyc();
        rsp_ready = 1'b1;
        enter_prog();
        prog_we = 1'b1;
        prog_addr = 8;  prog_wdata = 32'hDEADBEEF; cyc();
        prog_addr = 5;  prog_wdata = 32'h12345678; cyc();
        prog_we = 1'b0;
        cyc();
        prog_en = 1'b0;
        cyc();
        fetch(8);
        fetch(4);
        idle(2);

        // Reset with a full buffer and a pending request.
        rsp_ready = 1'b0;
        fetch(0);
        fetch(4);
        req_valid = 1'b1;
        req_addr  = 8;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req_valid = 1'b0;
        chk("rst_mid_data", rsp_data, 0);
        cyc();
        rsp_ready = 1'b1;
        fetch(0);
        idle(2);

        // Program strobe while running is ignored.
        prog_we = 1'b1;
        prog_addr = 0;
        prog_wdata = 32'hFFFFFFFF;
        req_valid = 1'b0;
        cyc();
        prog_we = 1'b0;
        cyc();
        fetch(0);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       req_addr = $urandom_range(0, DEPTH * 4 - 1) | 32'($urandom_range(1, 3));
                1:       req_addr = DEPTH * 4 + $urandom_range(0, 255) * 4;
                default: req_addr = $urandom_range(0, DEPTH - 1) * 4;
            endcase
            prog_en    = ((i % 80) >= 64);
            prog_we    = ($urandom_range(0, 1) == 1);
            prog_addr  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8191))
                                                     : 32'($urandom_range(0, DEPTH - 1) * 4);
            prog_wdata = $urandom;
            rst        = (i == 300);
            cyc();
        end
        rst = 1'b0;
        prog_en = 1'b0;
        prog_we = 1'b0;
        rsp_ready = 1'b1;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
